// File: rtl/param_unloader.sv
// Snapshots the network weights/biases and streams them out word by word.
// Optional header word (parameter count) enabled by PARAM_UNLOADER_HEADER_EN.
module param_unloader #(
  parameter int DATA_W = 16,
  parameter int L1 = 4,
  parameter int L2 = 8,
  parameter int L3 = 8,
  parameter int L4 = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [L2*L1*DATA_W-1:0] w1_in,
  input  logic [L3*L2*DATA_W-1:0] w2_in,
  input  logic [L4*L3*DATA_W-1:0] w3_in,
  input  logic [L2*DATA_W-1:0]   b1_in,
  input  logic [L3*DATA_W-1:0]   b2_in,
  input  logic [L4*DATA_W-1:0]   b3_in,
  output logic [DATA_W-1:0]      m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   busy,
  output logic                   done
);

  localparam int N = L2*L1 + L3*L2 + L4*L3 + L2 + L3 + L4;
`ifdef PARAM_UNLOADER_HEADER_EN
  localparam int TOTAL = N + 1;
`else
  localparam int TOTAL = N;
`endif
  localparam int IW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] bank [N];
  logic [BW-1:0]     sel;
  logic [DATA_W-1:0] word;
  logic              hs;
  logic              last;

  // Packed inputs concatenate directly into stream order (W1 in the LSBs).
  logic [N*DATA_W-1:0] flat;
  assign flat = {b3_in, b2_in, b1_in, w3_in, w2_in, w1_in};

  assign last = (idx == IW'(TOTAL - 1));
  assign hs   = (state == STREAM) && m_tready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      CAPTURE: state_nx = STREAM;
      STREAM:  if (hs && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (state == CAPTURE) begin
      idx <= '0;
    end else if (hs && !last) begin
      idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) bank[k] <= '0;
    end else if (state == CAPTURE) begin
      for (int k = 0; k < N; k++)
        bank[k] <= flat[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    sel  = BW'(idx);
    word = '0;
`ifdef PARAM_UNLOADER_HEADER_EN
    if (idx == '0) begin
      word = DATA_W'(N);
    end else begin
      sel  = BW'(idx - 1'b1);
      word = bank[sel];
    end
`else
    word = bank[sel];
`endif
  end

  assign m_tvalid = (state == STREAM);
  assign m_tdata  = m_tvalid ? word : '0;
  assign m_tlast  = m_tvalid && last;
  assign busy     = (state == CAPTURE) || (state == STREAM);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_param_unloader.sv
// Directed scoreboard bench for param_unloader at default sizes.
// Expected words come from a formula model pushed at start time.
module tb_param_unloader;

  localparam int DW = 16;
  localparam int N  = 121;
`ifdef PARAM_UNLOADER_HEADER_EN
  localparam int TOT = N + 1;
`else
  localparam int TOT = N;
`endif

  logic          clk = 0;
  logic          reset = 0;
  logic          start = 0;
  logic [511:0]  w1;
  logic [1023:0] w2;
  logic [127:0]  w3;
  logic [127:0]  b1;
  logic [127:0]  b2;
  logic [15:0]   b3;
  logic [15:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready = 0;
  logic          m_tlast;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb [$];

  param_unloader dut (
    .clk(clk), .reset(reset), .start(start),
    .w1_in(w1), .w2_in(w2), .w3_in(w3),
    .b1_in(b1), .b2_in(b2), .b3_in(b3),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int k);
    if (k < 32) return 16'(16 * (k / 4) + (k % 4));
    if (k < 96) return 16'(16'h100 + (k - 32));
    if (k < 104) return 16'(16'h200 + (k - 96));
    if (k < 112) return 16'(16'h300 + (k - 104));
    if (k < 120) return 16'(16'h400 + (k - 112));
    return 16'(16'h500 + (k - 120));
  endfunction

  task automatic set_inputs();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++)
        w1[(i*4+j)*16 +: 16] = 16'(16 * i + j);
    for (int k = 0; k < 64; k++) w2[k*16 +: 16] = 16'(16'h100 + k);
    for (int k = 0; k < 8; k++) w3[k*16 +: 16] = 16'(16'h200 + k);
    for (int k = 0; k < 8; k++) b1[k*16 +: 16] = 16'(16'h300 + k);
    for (int k = 0; k < 8; k++) b2[k*16 +: 16] = 16'(16'h400 + k);
    b3 = 16'h500;
  endtask

  task automatic push_expected();
    sb.delete();
`ifdef PARAM_UNLOADER_HEADER_EN
    sb.push_back(16'(N));
`endif
    for (int k = 0; k < N; k++) sb.push_back(model(k));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, 32'(m_tvalid), 0);
    check({tag, "_tlast"}, 32'(m_tlast), 0);
    check({tag, "_tdata"}, 32'(m_tdata), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // mode 1: ready follows 0,1,0,1... so each word costs two cycles.
  task automatic xfer(input int mode, input int restart_at,
                      input int rst_at, input bit chg,
                      output int cyc, output int nw);
    bit stalled = 0;
    logic [15:0] pd = '0;
    logic pl = 0;
    logic [15:0] e;
    bit rdy;
    cyc = 0;
    nw = 0;
    push_expected();
    start = 1;
    @(negedge clk);
    start = 0;
    check("cap_busy", 32'(busy), 1);
    check("cap_tvalid", 32'(m_tvalid), 0);
    @(negedge clk);
    if (chg) begin
      w1 = '1; w2 = '1; w3 = '1;
      b1 = '1; b2 = '1; b3 = '1;
    end
    for (int t = 0; t < 1000; t++) begin
      if (t > 0) @(negedge clk);
      start = 0;
      if (!m_tvalid) begin
        check("tvalid_in_stream", 32'(m_tvalid), 1);
        return;
      end
      cyc++;
      if (stalled) begin
        check("stall_tdata", 32'(m_tdata), 32'(pd));
        check("stall_tlast", 32'(m_tlast), 32'(pl));
      end
      rdy = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      m_tready = rdy;
      stalled = !rdy;
      pd = m_tdata;
      pl = m_tlast;
      if (rdy) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 1);
          return;
        end
        e = sb.pop_front();
        nw++;
        check($sformatf("word%0d", nw), 32'(m_tdata), 32'(e));
        check($sformatf("tlast%0d", nw), 32'(m_tlast),
              32'(sb.size() == 0));
        if (nw == restart_at) start = 1;
        if (nw == rst_at) begin
          #1 reset = 0;
          #1 check_zero("rst_async");
          @(negedge clk);
          check_zero("rst_hold");
          reset = 1;
          m_tready = 0;
          sb.delete();
          return;
        end
        if (sb.size() == 0) break;
      end
    end
    @(negedge clk);
    start = 0;
    m_tready = 0;
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_tvalid", 32'(m_tvalid), 0);
    @(negedge clk);
    check("done_clear", 32'(done), 0);
  endtask

  int cyc;
  int nw;
  int extra;

  initial begin
    set_inputs();
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_zero("idle");

    xfer(0, 0, 0, 0, cyc, nw);
    check("t1_words", 32'(nw), 32'(TOT));
    check("t1_cycles", 32'(cyc), 32'(TOT));

    xfer(1, 0, 0, 0, cyc, nw);
    check("t2_words", 32'(nw), 32'(TOT));
    check("t2_cycles", 32'(cyc), 32'(2 * TOT));

    xfer(0, 0, 0, 1, cyc, nw);
    check("t3_words", 32'(nw), 32'(TOT));
    set_inputs();

    xfer(0, 50, 0, 0, cyc, nw);
    check("t4_words", 32'(nw), 32'(TOT));
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      extra += int'(done) + int'(m_tvalid) + int'(busy);
    end
    check("t4_no_restart", 32'(extra), 0);

    xfer(0, 0, 60, 0, cyc, nw);
    check("t5_words_at_rst", 32'(nw), 60);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      extra += int'(done) + int'(m_tvalid) + int'(busy);
    end
    check("t5_no_done", 32'(extra), 0);

    xfer(0, 0, 0, 0, cyc, nw);
    check("t6_words", 32'(nw), 32'(TOT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_unloader.md
PARAM_UNLOADER -- requirements
Module: param_unloader

Interface
REQ-001 Parameter DATA_W, default 16, width of one fixed-point parameter word (the network data_type).
REQ-002 Parameters L1, L2, L3, L4, defaults 4, 8, 8, 1, layer sizes matching the network instance.
REQ-003 Derived constant N = L2*L1 + L3*L2 + L4*L3 + L2 + L3 + L4, the parameter word count (121 at defaults).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to snapshot and stream the parameters.
REQ-007 w1_in  in  L2*L1*DATA_W  W1 array; element [i][j] at bits (i*L1+j)*DATA_W +: DATA_W.
REQ-008 w2_in  in  L3*L2*DATA_W  W2 array; same packing, row length L2.
REQ-009 w3_in  in  L4*L3*DATA_W  W3 array; same packing, row length L3.
REQ-010 b1_in / b2_in / b3_in  in  L2*DATA_W / L3*DATA_W / L4*DATA_W  bias vectors; element [i] at bits i*DATA_W +: DATA_W.
REQ-011 m_tdata  out  DATA_W  stream data word.
REQ-012 m_tvalid  out  1  stream word valid.
REQ-013 m_tready  in  1  downstream accept.
REQ-014 m_tlast  out  1  marks the final word of a transfer.
REQ-015 busy  out  1  high from snapshot until the final handshake.
REQ-016 done  out  1  single-cycle pulse the cycle after the final handshake.

Function
REQ-017 The FSM SHALL have states IDLE, CAPTURE, STREAM, DONE.
REQ-018 IDLE: start=1 SHALL move to CAPTURE; other inputs are ignored.
REQ-019 CAPTURE (one cycle): all six inputs SHALL be registered into an internal snapshot bank; word index cleared to 0; next state STREAM.
REQ-020 Streaming SHALL read the snapshot only, so input changes after CAPTURE do not affect the transfer.
REQ-021 Word order SHALL be W1, W2, W3 row-major (row i, then column j), then b1, b2, b3 by ascending index.
REQ-022 STREAM: m_tvalid=1 and m_tdata=snapshot[index]; a handshake is m_tvalid & m_tready on a rising edge.
REQ-023 Each handshake SHALL increment the index by 1; without a handshake m_tdata and m_tlast SHALL hold stable.
REQ-024 m_tlast SHALL be 1 only while the final word is presented.
REQ-025 A handshake on the final word SHALL move to DONE; DONE asserts done for one cycle, then returns to IDLE.
REQ-026 busy SHALL be 1 in CAPTURE and STREAM and 0 in IDLE and DONE.
REQ-027 start while not in IDLE SHALL be ignored (no restart, no queuing).
REQ-028 Latency: first word SHALL be valid 2 cycles after start is sampled (IDLE->CAPTURE->STREAM).
REQ-029 With m_tready held at 1, a transfer SHALL take exactly N STREAM cycles.
REQ-030 m_tvalid SHALL never deassert in STREAM before the final handshake.
REQ-031 Data words SHALL be passed bit-exact, with no arithmetic, truncation or sign change.

Reset
REQ-032 reset low SHALL asynchronously force IDLE, index 0, m_tvalid=0, m_tlast=0, busy=0, done=0, m_tdata=0.
REQ-033 The snapshot bank SHALL reset to all zeros.
REQ-034 Reset asserted mid-transfer SHALL abort it with no done pulse; the next transfer requires a new start.

Configuration
REQ-035 Macro PARAM_UNLOADER_HEADER_EN: when defined, one header word SHALL precede the parameters, carrying N zero-extended to DATA_W bits; the transfer becomes N+1 words and the first parameter word appears 3 cycles after start.
REQ-036 Without PARAM_UNLOADER_HEADER_EN, no header SHALL be emitted and the transfer is exactly N words.

Verification
REQ-037 Defaults, W1[i][j]=16*i+j, W2 = 0x100+index, W3 = 0x200+index, b1/b2/b3 = 0x300/0x400/0x500+index, tready=1, pulse start -> 121 words in REQ-021 order, last word 0x500, tlast only on word 121, done pulse 1 cycle later.
REQ-038 tready toggled in a 1-0 pattern -> identical word sequence; data and tlast stable on every stalled cycle; 242 STREAM cycles.
REQ-039 Inputs changed to all 0xFFFF the cycle after CAPTURE -> streamed words still match the pre-change values.
REQ-040 Second start pulse at word 50 -> ignored; exactly 121 words and one done pulse.
REQ-041 reset driven low at word 60, then high, then start -> outputs zero during reset, no done pulse, new transfer begins again at word 0 (W1[0][0]).
REQ-042 With PARAM_UNLOADER_HEADER_EN defined -> first word 0x0079 (121), then the REQ-037 sequence; 122 words total.
